// File: rtl/gauss_blur_3x3.sv
// gauss_blur_3x3: streaming 3x3 Gaussian smoothing filter for raster-order
// 8-bit grayscale video. Two line buffers plus a two-column window register
// supply the previous rows and columns; the live column is taken straight from
// the line-buffer read ports and pixel_in, so each accepted beat yields its
// result one cycle later. Border beats (row < 2 or column < 2) pass through.
`timescale 1ns/1ps

module gauss_blur_3x3 #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pixel_in,
  input  logic       valid_in,
  output logic [7:0] pixel_out,
  output logic       valid_out,
  output logic       eof_out
);

  // Counter widths are kept at least 2 bits so the "position >= 2" border test
  // stays meaningful even for tiny test images.
  localparam int CW = (WIDTH  > 4) ? $clog2(WIDTH)  : 2;
  localparam int RW = (HEIGHT > 4) ? $clog2(HEIGHT) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  // Raster position of the next accepted beat
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Registered outputs
  logic [7:0] pixel_out_q, pixel_out_d;
  logic       valid_out_q, valid_out_d;
  logic       eof_out_q, eof_out_d;

  // Line buffers: line1 holds row r-1, line2 holds row r-2 (RAM-style, no reset)
  logic [7:0] line1_mem [WIDTH];
  logic [7:0] line2_mem [WIDTH];
  logic [7:0] line1_rd;
  logic [7:0] line2_rd;

  // Window columns c-1 (suffix _1) and c-2 (suffix _2) for rows r-2 (top),
  // r-1 (mid) and r (bot); column c is formed from the live read data.
  logic [7:0] win_top_1_q, win_top_1_d, win_top_2_q, win_top_2_d;
  logic [7:0] win_mid_1_q, win_mid_1_d, win_mid_2_q, win_mid_2_d;
  logic [7:0] win_bot_1_q, win_bot_1_d, win_bot_2_q, win_bot_2_d;

  // Kernel datapath
  logic [11:0] blur_sum;
  logic [7:0]  blur_pix;
  logic        is_interior;
  logic        is_last_beat;

  // Kernel weight helpers: zero-extend a pixel to 12 bits scaled by 1, 2 or 4
  function automatic logic [11:0] wt1(input logic [7:0] p);
    return {4'd0, p};
  endfunction

  function automatic logic [11:0] wt2(input logic [7:0] p);
    return {3'd0, p, 1'b0};
  endfunction

  function automatic logic [11:0] wt4(input logic [7:0] p);
    return {2'd0, p, 2'b0};
  endfunction

  assign line1_rd = line1_mem[col_q];
  assign line2_rd = line2_mem[col_q];

  // Position classification of the beat currently presented
  always_comb begin
    is_interior  = (row_q >= RW'(2)) && (col_q >= CW'(2));
    is_last_beat = (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  // Weighted 3x3 sum with round-to-nearest divide by 16 (max sum 4080 fits 12 bits)
  always_comb begin
    blur_sum = wt1(win_top_2_q) + wt2(win_top_1_q) + wt1(line2_rd)
             + wt2(win_mid_2_q) + wt4(win_mid_1_q) + wt2(line1_rd)
             + wt1(win_bot_2_q) + wt2(win_bot_1_q) + wt1(pixel_in);
    blur_pix = 8'((blur_sum + 12'd8) >> 4);
  end

  // Column/row counters advance only on accepted beats and wrap at frame end
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Output beat: blurred interior, echoed border, held value when idle
  always_comb begin
    valid_out_d = valid_in;
    eof_out_d   = valid_in && is_last_beat;
    pixel_out_d = pixel_out_q;
    if (valid_in) begin
      pixel_out_d = is_interior ? blur_pix : pixel_in;
    end
  end

  // Window shift: older column moves to _2, live column enters _1
  always_comb begin
    win_top_1_d = win_top_1_q;
    win_top_2_d = win_top_2_q;
    win_mid_1_d = win_mid_1_q;
    win_mid_2_d = win_mid_2_q;
    win_bot_1_d = win_bot_1_q;
    win_bot_2_d = win_bot_2_q;
    if (valid_in) begin
      win_top_2_d = win_top_1_q;
      win_top_1_d = line2_rd;
      win_mid_2_d = win_mid_1_q;
      win_mid_1_d = line1_rd;
      win_bot_2_d = win_bot_1_q;
      win_bot_1_d = pixel_in;
    end
  end

  // Control and output registers, cleared immediately by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      pixel_out_q <= '0;
      valid_out_q <= 1'b0;
      eof_out_q   <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pixel_out_q <= pixel_out_d;
      valid_out_q <= valid_out_d;
      eof_out_q   <= eof_out_d;
    end
  end

  // Window registers carry no reset; border pass-through hides stale contents
  always_ff @(posedge clk) begin
    win_top_1_q <= win_top_1_d;
    win_top_2_q <= win_top_2_d;
    win_mid_1_q <= win_mid_1_d;
    win_mid_2_q <= win_mid_2_d;
    win_bot_1_q <= win_bot_1_d;
    win_bot_2_q <= win_bot_2_d;
  end

  // Line buffers age by one row at the current column on each accepted beat
  always_ff @(posedge clk) begin
    if (valid_in) begin
      line2_mem[col_q] <= line1_rd;
      line1_mem[col_q] <= pixel_in;
    end
  end

  assign pixel_out = pixel_out_q;
  assign valid_out = valid_out_q;
  assign eof_out   = eof_out_q;

endmodule

// File: tb/tb_gauss_blur_3x3.sv
// tb_gauss_blur_3x3: directed self-checking bench for gauss_blur_3x3 using a
// 4x4 instance for frame/impulse/gap/reset scenarios and an 8x8 instance for
// the all-white saturation case. Expected values are hand-computed constants.
`timescale 1ns/1ps

module tb_gauss_blur_3x3;

  logic clk = 1'b0;
  logic rst;

  logic [7:0] pix4_in, pix4_out;
  logic       vin4, vout4, eof4;
  logic [7:0] pix8_in, pix8_out;
  logic       vin8, vout8, eof8;

  int errors = 0;
  int checks = 0;

  logic [7:0] frame_pix [16];
  logic [7:0] frame_exp [16];

  gauss_blur_3x3 #(.WIDTH(4), .HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .pixel_in(pix4_in), .valid_in(vin4),
    .pixel_out(pix4_out), .valid_out(vout4), .eof_out(eof4)
  );

  gauss_blur_3x3 #(.WIDTH(8), .HEIGHT(8)) dut8 (
    .clk(clk), .rst(rst), .pixel_in(pix8_in), .valid_in(vin8),
    .pixel_out(pix8_out), .valid_out(vout8), .eof_out(eof8)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports the failure
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle into the 4x4 instance, then sample just after the edge
  task automatic apply_stimulus(input logic [7:0] pix, input logic valid);
    @(negedge clk);
    pix4_in = pix;
    vin4    = valid;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle into the 8x8 instance, then sample just after the edge
  task automatic apply_stimulus8(input logic [7:0] pix, input logic valid);
    @(negedge clk);
    pix8_in = pix;
    vin8    = valid;
    @(posedge clk);
    #1;
  endtask

  // Fill the 4x4 frame tables with a flat image
  task automatic set_uniform(input logic [7:0] v);
    for (int i = 0; i < 16; i++) begin
      frame_pix[i] = v;
      frame_exp[i] = v;
    end
  endtask

  // Fill a 255 impulse at index idx; interior outputs (2,2),(2,3),(3,2),(3,3)
  task automatic set_impulse(input int idx, input logic [7:0] e10, input logic [7:0] e11,
                             input logic [7:0] e14, input logic [7:0] e15);
    for (int i = 0; i < 16; i++) begin
      frame_pix[i] = (i == idx) ? 8'd255 : 8'd0;
      frame_exp[i] = frame_pix[i];
    end
    frame_exp[10] = e10;
    frame_exp[11] = e11;
    frame_exp[14] = e14;
    frame_exp[15] = e15;
  endtask

  // Stream the 4x4 frame tables, inserting gap idle cycles after each beat
  task automatic run_frame4(input string tag, input int gap);
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(frame_pix[i], 1'b1);
      check_output($sformatf("%s valid[%0d]", tag, i), 32'(vout4), 32'd1);
      check_output($sformatf("%s pix[%0d]", tag, i), 32'(pix4_out), 32'(frame_exp[i]));
      check_output($sformatf("%s eof[%0d]", tag, i), 32'(eof4), (i == 15) ? 32'd1 : 32'd0);
      for (int g = 0; g < gap; g++) begin
        apply_stimulus(8'd9, 1'b0);
        check_output($sformatf("%s gapvalid[%0d]", tag, i), 32'(vout4), 32'd0);
        check_output($sformatf("%s gapeof[%0d]", tag, i), 32'(eof4), 32'd0);
        check_output($sformatf("%s gaphold[%0d]", tag, i), 32'(pix4_out), 32'(frame_exp[i]));
      end
    end
  endtask

  initial begin
    $display("[TB] gauss_blur_3x3 directed bench");
    rst = 1'b1;
    pix4_in = 8'd0;
    vin4 = 1'b0;
    pix8_in = 8'd0;
    vin8 = 1'b0;

    // Reset acts without a clock edge
    #2 rst = 1'b0;
    #1;
    check_output("reset pix", 32'(pix4_out), 32'd0);
    check_output("reset valid", 32'(vout4), 32'd0);
    check_output("reset eof", 32'(eof4), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Flat 100 frame, back-to-back, then one idle cycle
    set_uniform(8'd100);
    run_frame4("flat100", 0);
    apply_stimulus(8'd9, 1'b0);
    check_output("idle valid", 32'(vout4), 32'd0);
    check_output("idle eof", 32'(eof4), 32'd0);
    check_output("idle hold", 32'(pix4_out), 32'd100);

    // Impulses placed so every kernel weight position gets exercised
    set_impulse(5, 8'd64, 8'd32, 8'd32, 8'd16);
    run_frame4("imp11", 0);
    set_impulse(10, 8'd16, 8'd32, 8'd32, 8'd64);
    run_frame4("imp22", 0);
    set_impulse(6, 8'd32, 8'd64, 8'd16, 8'd32);
    run_frame4("imp12", 0);
    set_impulse(9, 8'd32, 8'd16, 8'd64, 8'd32);
    run_frame4("imp21", 0);

    // valid_in pattern 1,0,0 with junk pixels during the gaps
    set_uniform(8'd100);
    run_frame4("gap100", 2);
    set_impulse(5, 8'd64, 8'd32, 8'd32, 8'd16);
    run_frame4("gapimp", 2);

    // Reset mid-frame after six beats abandons the frame
    set_uniform(8'd100);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(8'd100, 1'b1);
      check_output($sformatf("pre-reset pix[%0d]", i), 32'(pix4_out), 32'd100);
    end
    @(negedge clk);
    vin4 = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_output("midreset pix", 32'(pix4_out), 32'd0);
    check_output("midreset valid", 32'(vout4), 32'd0);
    check_output("midreset eof", 32'(eof4), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_frame4("postreset", 0);

    // Two back-to-back frames: no leakage of frame 1 into frame 2
    set_uniform(8'd200);
    run_frame4("frameA200", 0);
    set_uniform(8'd50);
    run_frame4("frameB50", 0);
    apply_stimulus(8'd0, 1'b0);

    // 8x8 all-white frame: no overflow, eof on the 64th beat
    for (int i = 0; i < 64; i++) begin
      apply_stimulus8(8'd255, 1'b1);
      check_output($sformatf("white valid[%0d]", i), 32'(vout8), 32'd1);
      check_output($sformatf("white pix[%0d]", i), 32'(pix8_out), 32'd255);
      check_output($sformatf("white eof[%0d]", i), 32'(eof8), (i == 63) ? 32'd1 : 32'd0);
    end
    apply_stimulus8(8'd0, 1'b0);
    check_output("white idle valid", 32'(vout8), 32'd0);
    check_output("white idle eof", 32'(eof8), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
